// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states, byte-lane masks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(input logic wen, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~wen;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: store mask/replication, load lane extraction and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    wmask     = '0;
    wdata_rep = '0;
    misalign  = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        wmask     = 4'(MASK_B << addr_lo);
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        wmask     = 4'(MASK_H << {addr_lo[1], 1'b0});
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      2'b10: begin
        wmask     = MASK_W;
        wdata_rep = wdata;
        misalign  = |addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = '0;
    case (funct3)
      F3_B:    rdata_ext = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    rdata_ext = {{16{rd_half[15]}}, rd_half};
      F3_W:    rdata_ext = rdata;
      F3_BU:   rdata_ext = {24'd0, rd_byte};
      F3_HU:   rdata_ext = {16'd0, rd_half};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one SRAM access at a time, stalling execute while in flight.
// Optional ack timeout enabled by defining LSU_TIMEOUT_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              hold_o,
  output logic              resp_valid,
  output logic              resp_err,
  output logic              resp_wen,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_rdata,
  output logic              mem_sel,
  output logic              mem_wen,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  state_e            state_q, state_d;
  logic              wen_q, wen_d;
  logic              err_q, err_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mem_sel_q, mem_sel_d;
  logic              mem_wen_q, mem_wen_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic        idle;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;

  assign idle = (state_q == ST_IDLE);

  // One aligner serves both ends: live request in IDLE, latched request otherwise.
  assign al_funct3  = idle ? req_funct3    : funct3_q;
  assign al_addr_lo = idle ? req_addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .funct3    (al_funct3),
    .addr_lo   (al_addr_lo),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .wmask     (al_wmask),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign)
  );

  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    err_d       = err_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    rdata_d     = rdata_q;
    mem_sel_d   = mem_sel_q;
    mem_wen_d   = mem_wen_q;
    mem_wmask_d = mem_wmask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d     = req_wen;
          funct3_d  = req_funct3;
          addr_lo_d = req_addr[1:0];
          rd_d      = req_rd;
          rdata_d   = '0;
          if (!f3_legal(req_wen, req_funct3) || al_misalign) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d       = 1'b0;
            state_d     = ST_BUS;
            mem_sel_d   = 1'b1;
            mem_wen_d   = req_wen;
            mem_wmask_d = req_wen ? al_wmask : '0;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = req_wen ? al_wdata : '0;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      ST_BUS: begin
        if (mem_ack) begin
          rdata_d     = wen_q ? '0 : al_rdata;
          state_d     = ST_DONE;
          mem_sel_d   = 1'b0;
          mem_wen_d   = 1'b0;
          mem_wmask_d = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d       = 1'b1;
          state_d     = ST_DONE;
          mem_sel_d   = 1'b0;
          mem_wen_d   = 1'b0;
          mem_wmask_d = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wen_q       <= 1'b0;
      err_q       <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      rd_q        <= '0;
      rdata_q     <= '0;
      mem_sel_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_wmask_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      err_q       <= err_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      mem_sel_q   <= mem_sel_d;
      mem_wen_q   <= mem_wen_d;
      mem_wmask_q <= mem_wmask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign hold_o     = (idle && req_valid) || (state_q == ST_BUS);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_err   = resp_valid && err_q;
  assign resp_wen   = resp_valid && !wen_q && !err_q && (rd_q != 5'd0);
  assign resp_rd    = rd_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

  assign mem_sel   = mem_sel_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: per-cycle comparison against a transaction-level model.
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        hold_o, resp_valid, resp_err, resp_wen;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata;
  logic        mem_sel, mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  bit          e_hold, e_sel, e_mwen, e_valid, e_err, e_rwen;
  logic [3:0]  e_mask;
  logic [31:0] e_maddr, e_mwdata, e_rdata;
  logic [4:0]  e_rd;

  lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .hold_o(hold_o), .resp_valid(resp_valid), .resp_err(resp_err), .resp_wen(resp_wen),
    .resp_rd(resp_rd), .resp_rdata(resp_rdata), .mem_sel(mem_sel), .mem_wen(mem_wen),
    .mem_wmask(mem_wmask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [3:0]  mask;
    logic [31:0] wd;
    logic [31:0] rd_ext;
    bit          rwen;
  } exp_t;

  // Transaction-level reference: access size, lane offset and sign rule from funct3.
  function automatic exp_t model(bit wen, logic [2:0] f3, logic [31:0] addr,
                                 logic [31:0] wdata, logic [31:0] rdata, logic [4:0] rd);
    exp_t   e;
    int     size, off;
    bit     sgn;
    longint v;
    size = 0; sgn = 0;
    case (f3)
      3'b000: begin size = 1; sgn = 1; end
      3'b001: begin size = 2; sgn = 1; end
      3'b010: begin size = 4; sgn = 0; end
      3'b100: begin size = 1; sgn = 0; end
      3'b101: begin size = 2; sgn = 0; end
      default: size = 0;
    endcase
    off = int'(addr % 4);
    if (size == 0 || (wen && f3[2])) e.err = 1;
    else e.err = (off % size) != 0;
    e.mask = '0; e.wd = '0; e.rd_ext = '0;
    if (!e.err) begin
      for (int j = 0; j < 4; j++) begin
        if (wen && j >= off && j < off + size) e.mask[j] = 1'b1;
        e.wd[8*j +: 8] = wdata[8*(j % size) +: 8];
      end
      v = longint'(rdata >> (8 * off)) & ((64'sd1 <<< (8 * size)) - 1);
      if (sgn && v[8*size-1]) v = v - (64'sd1 <<< (8 * size));
      e.rd_ext = wen ? 32'd0 : v[31:0];
    end
    e.rwen = !wen && !e.err && rd != 0;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("hold_o", 32'(hold_o), 32'(e_hold));
      chk("mem_sel", 32'(mem_sel), 32'(e_sel));
      chk("resp_valid", 32'(resp_valid), 32'(e_valid));
      if (e_sel) begin
        chk("mem_wen", 32'(mem_wen), 32'(e_mwen));
        chk("mem_addr", mem_addr, e_maddr);
        chk("mem_wmask", 32'(mem_wmask), 32'(e_mask));
        if (e_mwen) chk("mem_wdata", mem_wdata, e_mwdata);
      end
      if (e_valid) begin
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("resp_wen", 32'(resp_wen), 32'(e_rwen));
        chk("resp_rd", 32'(resp_rd), 32'(e_rd));
        if (!e_err) chk("resp_rdata", resp_rdata, e_rdata);
      end
    end
  end

  task automatic idle_exp(bit h);
    e_hold = h; e_sel = 0; e_mwen = 0; e_valid = 0; e_err = 0; e_rwen = 0;
    e_mask = '0; e_maddr = '0; e_mwdata = '0; e_rdata = '0; e_rd = '0;
  endtask

  // k = BUS cycle carrying ack (1..), 0 = never ack (timeout build only).
  task automatic access(bit wen, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                        logic [31:0] rdata, logic [4:0] rd, int k, bit busy_valid, bit stray_ack);
    exp_t m;
    int   nbus;
    bit   tmo;
    m    = model(wen, f3, addr, wdata, rdata, rd);
    tmo  = (k == 0);
    nbus = tmo ? TO : k;
    @(posedge clk); #1;
    req_valid = 1; req_wen = wen; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd; mem_ack = 0; mem_rdata = rdata;
    idle_exp(1);
    if (!m.err) begin
      for (int i = 1; i <= nbus; i++) begin
        @(posedge clk); #1;
        if (busy_valid) begin
          req_wen = ~wen; req_funct3 = 3'b000; req_addr = 32'h0000_0F00; req_rd = 5'd31;
        end else begin
          req_valid = 0;
        end
        mem_ack = (!tmo && i == k);
        e_hold = 1; e_sel = 1; e_mwen = wen; e_valid = 0;
        e_maddr = addr & ~32'd3; e_mask = m.mask; e_mwdata = m.wd;
      end
    end
    @(posedge clk); #1;
    mem_ack = 0;
    req_valid = busy_valid;
    e_hold = busy_valid ? 0 : 0; e_sel = 0; e_valid = 1;
    e_err = m.err || tmo; e_rwen = tmo ? 0 : m.rwen; e_rd = rd; e_rdata = m.rd_ext;
    @(posedge clk); #1;
    req_valid = 0; mem_ack = stray_ack;
    idle_exp(0);
  endtask

  initial begin
    exp_t p;
    // Hand-computed pins on the model itself.
    p = model(1, 3'b000, 32'h103, 32'hA5, 32'h0, 5'd0);
    chk("model_sb_mask", 32'(p.mask), 32'h8);
    chk("model_sb_wdata", p.wd, 32'hA5A5A5A5);
    p = model(0, 3'b000, 32'h102, 32'h0, 32'h12808034, 5'd5);
    chk("model_lb", p.rd_ext, 32'hFFFFFF80);
    p = model(0, 3'b100, 32'h102, 32'h0, 32'h12808034, 5'd5);
    chk("model_lbu", p.rd_ext, 32'h00000080);
    p = model(0, 3'b001, 32'h101, 32'h0, 32'h0, 5'd5);
    chk("model_lh_misalign", 32'(p.err), 32'd1);
    p = model(1, 3'b001, 32'h106, 32'h1234BEEF, 32'h0, 5'd0);
    chk("model_sh_mask", 32'(p.mask), 32'hC);

    idle_exp(0);
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(posedge clk); #1 rst = 0;

    access(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 5'd0, 2, 0, 0);
    access(1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 5'd0, 1, 0, 1);
    access(0, 3'b000, 32'h102, 32'h0, 32'h12808034, 5'd5, 1, 1, 0);
    access(0, 3'b100, 32'h102, 32'h0, 32'h12808034, 5'd5, 3, 0, 0);
    access(0, 3'b001, 32'h101, 32'h0, 32'h12808034, 5'd5, 1, 0, 1);
    access(0, 3'b010, 32'h102, 32'h0, 32'h12808034, 5'd6, 1, 0, 0);
    access(0, 3'b010, 32'h104, 32'h0, 32'h12808034, 5'd0, 1, 0, 0);
    access(1, 3'b001, 32'h106, 32'h1234BEEF, 32'h0, 5'd0, 2, 0, 0);
    access(0, 3'b101, 32'h102, 32'h0, 32'h8001F00D, 5'd7, 1, 0, 0);
    access(0, 3'b001, 32'h100, 32'h0, 32'h8001F00D, 5'd8, 1, 0, 0);
    access(0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd9, 1, 0, 0);
    access(1, 3'b100, 32'h100, 32'h0, 32'h0, 5'd0, 1, 0, 0);

    // Reset while in BUS, then a late ack.
    @(posedge clk); #1;
    req_valid = 1; req_wen = 0; req_funct3 = 3'b010; req_addr = 32'h200; req_rd = 5'd3;
    mem_rdata = 32'hCAFEF00D; mem_ack = 0;
    idle_exp(1);
    @(posedge clk); #1;
    req_valid = 0; rst = 1;
    e_hold = 1; e_sel = 1; e_mwen = 0; e_maddr = 32'h200; e_mask = '0;
    @(posedge clk); #1;
    rst = 0; mem_ack = 1;
    idle_exp(0);
    @(posedge clk); #1;
    mem_ack = 0;
    idle_exp(0);
    access(0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 5'd3, 1, 0, 0);

`ifdef LSU_TIMEOUT_EN
    access(0, 3'b010, 32'h300, 32'h0, 32'h11112222, 5'd4, 0, 0, 0);
    access(0, 3'b010, 32'h300, 32'h0, 32'h11112222, 5'd4, TO, 0, 0);
`endif

    @(posedge clk); #1;
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit between the execute stage's memory request and the data SRAM port (sel/we/byte_en/addr/din/dout/ack).
- Sequences one access at a time and stalls the execute stage while the access is in flight.
- Stores: generates the byte-lane mask and lane-replicated write data.
- Loads: extracts the addressed byte/halfword lane and sign/zero-extends it into a register writeback.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 255, maximum BUS-state cycles without ack before abort. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  execute stage presents a memory instruction.
- req_wen  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  32  rs2 store data.
- req_rd  in  5  load destination register.
- hold_o  out  1  stall to execute stage and fetch.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  misaligned, illegal or timed-out access; qualified by resp_valid.
- resp_wen  out  1  register write enable.
- resp_rd  out  5  register write address.
- resp_rdata  out  32  extended load data.
- mem_sel  out  1  SRAM select.
- mem_wen  out  1  SRAM write enable.
- mem_wmask  out  4  SRAM byte enables.
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0]=00).
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  SRAM read word.
- mem_ack  in  1  SRAM completion.

Behaviour:
- Reset values: state IDLE; all outputs 0.
- States: IDLE, BUS, DONE.
- hold_o is combinational: 1 when (IDLE & req_valid) or when in BUS; 0 in IDLE without a request and 0 in DONE.
- IDLE, req_valid=1: latch the request.
  - Illegal funct3 (011, 11x; store funct3 other than 000/001/010), halfword with addr[0]=1, or word with addr[1:0]≠00: go to DONE with an error. No memory access.
  - Otherwise go to BUS.
- BUS:
  - mem_sel=1 with all mem_* outputs registered and stable until ack.
  - Store mask: SB 0001<<addr[1:0]; SH 0011<<{addr[1],0}; SW 1111. Load mask: 0000.
  - Store wdata: SB {4{b}}; SH {2{h}}; SW word.
  - When mem_ack=1: capture mem_rdata, go to DONE. mem_sel drops on that edge.
- DONE, lasts one cycle, then IDLE:
  - resp_valid=1.
  - Loads: resp_rdata = lane selected by the latched addr, sign-extended (LB/LH) or zero-extended (LBU/LHU); resp_wen = (rd≠0) & ~err.
  - Stores: resp_wen=0, resp_rdata=0.
  - Errors: resp_err=1, resp_wen=0.
- Latency: request accepted at cycle N. mem_sel=1 from N+1. With ack at N+k (k≥1), resp_valid at N+k+1. Error response at N+1.
- Boundaries:
  - req_valid while not IDLE is ignored; the execute stage must hold it under hold_o.
  - mem_ack outside BUS is ignored.
  - req_valid in DONE is not accepted until the following IDLE cycle.
  - rst mid-access returns to IDLE with mem_sel=0 next edge; no response is issued and a late ack is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a cycle counter (width clog2(TIMEOUT_CYCLES+1)) clears on BUS entry and increments each BUS cycle without ack.
  - At TIMEOUT_CYCLES: mem_sel drops, go to DONE with resp_err=1, resp_wen=0.
  - Ack in the same cycle as the limit wins; the access completes normally.
- Undefined: no counter; BUS waits indefinitely for ack.

Decomposition:
- Package lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), state encoding, mask constants (MASK_B=0001, MASK_H=0011, MASK_W=1111).
- Sub-module lsu_align (combinational):
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: wmask, replicated wdata, extended rdata, misalign flag.
  - lsu itself holds the FSM, request latch and timeout counter.

Test Plan:
- SW 0xDEADBEEF @0x100, ack after 2 cycles -> mem_addr=0x100, mem_wmask=1111, mem_wdata=0xDEADBEEF; resp_valid 3 cycles after accept; resp_wen=0; hold_o=1 throughout until DONE.
- SB 0x000000A5 @0x103 -> mem_addr=0x100, mem_wmask=1000, mem_wdata=0xA5A5A5A5.
- LB @0x102 and LBU @0x102, mem_rdata=0x12808034, rd=5 -> LB gives resp_rdata=0xFFFFFF80; LBU gives 0x00000080; resp_wen=1, resp_rd=5.
- LH @0x101 and LW @0x102 -> no mem_sel; at N+1 resp_valid=1, resp_err=1, resp_wen=0. LW with rd=0 -> resp_wen=0.
- Timeout (LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4), ack never asserted -> mem_sel high 4 cycles, then resp_err=1. Ack on cycle 4 -> normal completion.
- rst asserted in BUS, ack asserted the next cycle -> no resp_valid; mem_sel=0; hold_o=0; next request proceeds normally.
